mode_sequencer: RTL and testbench

Top-level mode FSM for the electronic-organ design. It generalises the menu/free/auto/study/play/key-set controller to NUM_KEYS keys, NUM_SONGS songs and a bounded difficulty range. It synchronises and edge-detects the button inputs and generates a free-running system tick clock. It drives one-hot mode enables, song, difficulty and play-mode selections, and the write port of the key-remap RAM. Player modules and display muxing sit downstream and consume its outputs.

---
 rtl/mode_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Top-level organ mode FSM: button conditioning, mode/song/difficulty selection,
// key-remap RAM write port and free-running tick clock. Optional: REMAP_DUP_CHECK_EN.
module mode_sequencer #(
  parameter int NUM_KEYS  = 7,
  parameter int NUM_SONGS = 2,
  parameter int DIFF_MIN  = 0,
  parameter int DIFF_MAX  = 6,
  parameter int DIFF_RST  = 4,
  parameter int TICK_DIV  = 100000,
  parameter int CLOCK_W   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               submit,
  input  logic                               cancel,
  input  logic                               oct_up,
  input  logic                               oct_down,
  input  logic [NUM_KEYS-1:0]                note_key,
  input  logic [NUM_KEYS-1:0]                length_key,
  input  logic                               clear_remap,
  output logic [3:0]                         state,
  output logic                               en_free,
  output logic                               en_auto,
  output logic                               en_stdy,
  output logic                               en_play,
  output logic                               en_remap,
  output logic [$clog2(NUM_SONGS+1)-1:0]     song,
  output logic [$clog2(DIFF_MAX+1)-1:0]      difficulty,
  output logic [1:0]                         play_mod,
  output logic                               remap_we,
  output logic [$clog2(NUM_KEYS)-1:0]        remap_addr,
  output logic [NUM_KEYS-1:0]                remap_data,
  output logic                               remap_clr,
  output logic                               dup_err,
  output logic [CLOCK_W-1:0]                 sys_clock
);

  localparam int SONG_W     = $clog2(NUM_SONGS+1);
  localparam int DIFF_W     = $clog2(DIFF_MAX+1);
  localparam int ADDR_W     = $clog2(NUM_KEYS);
  localparam int PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PLAY_MODES = 4;

  localparam logic [NUM_KEYS-1:0] ONE_K   = NUM_KEYS'(1'b1);
  localparam logic [ADDR_W-1:0]   K_FREE  = ADDR_W'(3'd0);
  localparam logic [ADDR_W-1:0]   K_AUTO  = ADDR_W'(3'd1);
  localparam logic [ADDR_W-1:0]   K_STDY  = ADDR_W'(3'd2);
  localparam logic [ADDR_W-1:0]   K_PLAY  = ADDR_W'(3'd3);
  localparam logic [ADDR_W-1:0]   K_REMAP = ADDR_W'(3'd4);

  typedef enum logic [3:0] {
    S_MENU     = 4'd0,
    S_FREE     = 4'd1,
    S_AUTO_SEL = 4'd2,
    S_AUTO_RUN = 4'd3,
    S_STDY_SEL = 4'd4,
    S_STDY_RUN = 4'd5,
    S_PLAY_SEL = 4'd6,
    S_PLAY_RUN = 4'd7,
    S_REMAP    = 4'd8
  } state_t;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != {NUM_KEYS{1'b0}}) && ((v & (v - ONE_K)) == {NUM_KEYS{1'b0}});
  endfunction

  function automatic logic [ADDR_W-1:0] key_idx(input logic [NUM_KEYS-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  // Enable vector order: {free, auto, stdy, play, remap}
  function automatic logic [4:0] en_of(input state_t s);
    case (s)
      S_FREE:     return 5'b10000;
      S_AUTO_RUN: return 5'b01000;
      S_STDY_RUN: return 5'b00100;
      S_PLAY_RUN: return 5'b00010;
      S_REMAP:    return 5'b00001;
      default:    return 5'b00000;
    endcase
  endfunction

  state_t                state_r;
  logic [4:0]            en_r;
  logic [SONG_W-1:0]     song_r;
  logic [DIFF_W-1:0]     diff_r;
  logic [1:0]            play_mod_r;
  logic                  we_r;
  logic                  clr_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [NUM_KEYS-1:0]   data_r;
  logic [ADDR_W-1:0]     slot_r;
  logic [PRESC_W-1:0]    presc_r;
  logic [CLOCK_W-1:0]    sys_r;

  logic [3:0]            btn_raw_s;
  logic [3:0]            sync1_r;
  logic [3:0]            sync2_r;
  logic [3:0]            prev_r;
  logic [3:0]            pulse_s;
  logic                  sub_p_s;
  logic                  can_p_s;
  logic                  up_p_s;
  logic                  dn_p_s;

  logic                  note_ok_s;
  logic                  len_ok_s;
  logic [ADDR_W-1:0]     note_i_s;
  logic [ADDR_W-1:0]     len_i_s;
  logic                  song_ok_s;
  logic                  cancel_s;
  logic                  remap_sub_s;
  logic                  dup_hit_s;
  logic                  write_s;

  assign btn_raw_s = {oct_down, oct_up, cancel, submit};

  // Two-flop synchroniser plus previous-value flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign pulse_s = sync2_r & ~prev_r;
  assign sub_p_s = pulse_s[0];
  assign can_p_s = pulse_s[1];
  assign up_p_s  = pulse_s[2];
  assign dn_p_s  = pulse_s[3];

  assign note_ok_s   = is_onehot(note_key);
  assign len_ok_s    = is_onehot(length_key);
  assign note_i_s    = key_idx(note_key);
  assign len_i_s     = key_idx(length_key);
  assign song_ok_s   = sub_p_s && note_ok_s && (int'(note_i_s) < NUM_SONGS);
  assign cancel_s    = can_p_s && (state_r != S_MENU);
  assign remap_sub_s = (state_r == S_REMAP) && !cancel_s && !clear_remap && sub_p_s && note_ok_s;
  assign write_s     = remap_sub_s && !dup_hit_s;

`ifdef REMAP_DUP_CHECK_EN
  logic [NUM_KEYS-1:0] used_r;
  logic                dup_r;
  logic                enter_remap_s;

  assign enter_remap_s = (state_r == S_MENU) && sub_p_s && note_ok_s && (note_i_s == K_REMAP);
  assign dup_hit_s     = |(note_key & used_r);

  // Per-session record of physical keys already written, plus duplicate-reject strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_r <= {NUM_KEYS{1'b0}};
      dup_r  <= 1'b0;
    end else begin
      dup_r <= remap_sub_s && dup_hit_s;
      if (enter_remap_s) begin
        used_r <= {NUM_KEYS{1'b0}};
      end else if (write_s) begin
        used_r <= used_r | note_key;
      end
    end
  end

  assign dup_err = dup_r;
`else
  assign dup_hit_s = 1'b0;
  assign dup_err   = 1'b0;
`endif

  // Mode FSM with registered enables, selections and remap write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_MENU;
      en_r       <= 5'b00000;
      song_r     <= {SONG_W{1'b0}};
      diff_r     <= DIFF_W'(DIFF_RST);
      play_mod_r <= 2'b00;
      we_r       <= 1'b0;
      clr_r      <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      data_r     <= {NUM_KEYS{1'b0}};
      slot_r     <= {ADDR_W{1'b0}};
    end else begin
      we_r  <= 1'b0;
      clr_r <= 1'b0;
      if (cancel_s) begin
        state_r <= S_MENU;
        en_r    <= en_of(S_MENU);
        song_r  <= {SONG_W{1'b0}};
      end else begin
        case (state_r)
          S_MENU: begin
            if (sub_p_s && note_ok_s) begin
              case (note_i_s)
                K_FREE: begin
                  state_r <= S_FREE;
                  en_r    <= en_of(S_FREE);
                end
                K_AUTO: begin
                  state_r <= S_AUTO_SEL;
                  en_r    <= en_of(S_AUTO_SEL);
                  song_r  <= {SONG_W{1'b0}};
                end
                K_STDY: begin
                  state_r <= S_STDY_SEL;
                  en_r    <= en_of(S_STDY_SEL);
                  song_r  <= {SONG_W{1'b0}};
                end
                K_PLAY: begin
                  state_r <= S_PLAY_SEL;
                  en_r    <= en_of(S_PLAY_SEL);
                  song_r  <= {SONG_W{1'b0}};
                  diff_r  <= DIFF_W'(DIFF_RST);
                end
                K_REMAP: begin
                  state_r <= S_REMAP;
                  en_r    <= en_of(S_REMAP);
                  slot_r  <= {ADDR_W{1'b0}};
                end
                default: state_r <= S_MENU;
              endcase
            end
          end
          S_AUTO_SEL: begin
            if (song_ok_s) begin
              song_r  <= SONG_W'(note_i_s) + SONG_W'(1'b1);
              state_r <= S_AUTO_RUN;
              en_r    <= en_of(S_AUTO_RUN);
            end
          end
          S_STDY_SEL: begin
            if (song_ok_s) begin
              song_r  <= SONG_W'(note_i_s) + SONG_W'(1'b1);
              state_r <= S_STDY_RUN;
              en_r    <= en_of(S_STDY_RUN);
            end
          end
          S_PLAY_SEL: begin
            if (song_ok_s) begin
              song_r     <= SONG_W'(note_i_s) + SONG_W'(1'b1);
              play_mod_r <= (len_ok_s && (int'(len_i_s) < PLAY_MODES)) ? 2'(len_i_s) : 2'b00;
              state_r    <= S_PLAY_RUN;
              en_r       <= en_of(S_PLAY_RUN);
            end else if (up_p_s && !dn_p_s) begin
              if (diff_r != DIFF_W'(DIFF_MAX)) diff_r <= diff_r + DIFF_W'(1'b1);
            end else if (dn_p_s && !up_p_s) begin
              if (diff_r != DIFF_W'(DIFF_MIN)) diff_r <= diff_r - DIFF_W'(1'b1);
            end
          end
          S_REMAP: begin
            // Clear takes priority over a coincident submit
            if (clear_remap) begin
              clr_r   <= 1'b1;
              state_r <= S_MENU;
              en_r    <= en_of(S_MENU);
            end else if (write_s) begin
              we_r   <= 1'b1;
              addr_r <= slot_r;
              data_r <= note_key;
              if (slot_r == ADDR_W'(NUM_KEYS-1)) begin
                slot_r  <= {ADDR_W{1'b0}};
                state_r <= S_MENU;
                en_r    <= en_of(S_MENU);
              end else begin
                slot_r <= slot_r + ADDR_W'(1'b1);
              end
            end
          end
          S_FREE, S_AUTO_RUN, S_STDY_RUN, S_PLAY_RUN: state_r <= state_r;
          default: begin
            state_r <= S_MENU;
            en_r    <= en_of(S_MENU);
          end
        endcase
      end
    end
  end

  // Prescaler and free-running tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PRESC_W{1'b0}};
      sys_r   <= {CLOCK_W{1'b0}};
    end else if (presc_r == PRESC_W'(TICK_DIV-1)) begin
      presc_r <= {PRESC_W{1'b0}};
      sys_r   <= sys_r + CLOCK_W'(1'b1);
    end else begin
      presc_r <= presc_r + PRESC_W'(1'b1);
    end
  end

  assign state      = state_r;
  assign en_free    = en_r[4];
  assign en_auto    = en_r[3];
  assign en_stdy    = en_r[2];
  assign en_play    = en_r[1];
  assign en_remap   = en_r[0];
  assign song       = song_r;
  assign difficulty = diff_r;
  assign play_mod   = play_mod_r;
  assign remap_we   = we_r;
  assign remap_addr = addr_r;
  assign remap_data = data_r;
  assign remap_clr  = clr_r;
  assign sys_clock  = sys_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed self-checking bench for mode_sequencer; remap writes are checked
// through an expected-write scoreboard queue.
module tb_mode_sequencer;

  localparam int NK = 7;
  localparam logic [3:0] B_SUB = 4'b0001;
  localparam logic [3:0] B_CAN = 4'b0010;
  localparam logic [3:0] B_UP  = 4'b0100;
  localparam logic [3:0] B_DN  = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          submit, cancel, oct_up, oct_down, clear_remap;
  logic [NK-1:0] note_key, length_key;
  logic [3:0]    state;
  logic          en_free, en_auto, en_stdy, en_play, en_remap;
  logic [1:0]    song;
  logic [2:0]    difficulty;
  logic [1:0]    play_mod;
  logic          remap_we;
  logic [2:0]    remap_addr;
  logic [NK-1:0] remap_data;
  logic          remap_clr;
  logic          dup_err;
  logic [31:0]   sys_clock;
  logic [4:0]    en_vec;

  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int dup_cnt = 0;
  int tcyc;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  mode_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .submit(submit), .cancel(cancel),
    .oct_up(oct_up), .oct_down(oct_down), .note_key(note_key),
    .length_key(length_key), .clear_remap(clear_remap), .state(state),
    .en_free(en_free), .en_auto(en_auto), .en_stdy(en_stdy),
    .en_play(en_play), .en_remap(en_remap), .song(song),
    .difficulty(difficulty), .play_mod(play_mod), .remap_we(remap_we),
    .remap_addr(remap_addr), .remap_data(remap_data), .remap_clr(remap_clr),
    .dup_err(dup_err), .sys_clock(sys_clock)
  );

  always #5 clk = ~clk;

  assign en_vec = {en_free, en_auto, en_stdy, en_play, en_remap};

  // Reference cycle count since reset release, for the tick clock model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcyc <= 0;
    else        tcyc <= tcyc + 1;
  end

  // Capture DUT write/clear/duplicate strobes away from the active edge
  always @(negedge clk) begin
    if (rst_n && remap_we)  obs_q.push_back({remap_addr, remap_data});
    if (rst_n && remap_clr) clr_cnt <= clr_cnt + 1;
    if (rst_n && dup_err)   dup_cnt <= dup_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop every captured write against the expected queue; nothing may be left over
  task automatic drain(input string tag);
    logic [9:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      chk(tag, 32'(o), 32'(e));
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic press(input logic [3:0] b);
    {oct_down, oct_up, cancel, submit} = b;
    repeat (4) @(negedge clk);
    {oct_down, oct_up, cancel, submit} = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic sub(input logic [NK-1:0] key);
    note_key = key;
    press(B_SUB);
  endtask

  initial begin
    logic [NK-1:0] key;
    int c0;
    rst_n = 1'b0;
    {submit, cancel, oct_up, oct_down, clear_remap} = 5'b00000;
    note_key = 7'b0000000;
    length_key = 7'b0000000;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(en_vec), 32'd0);
    chk("rst_song", 32'(song), 32'd0);
    chk("rst_diff", 32'(difficulty), 32'd4);
    chk("rst_strobes", 32'({remap_we, remap_clr, dup_err, play_mod}), 32'd0);
    chk("rst_addr_data", 32'({remap_addr, remap_data}), 32'd0);
    chk("rst_sys", sys_clock, 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("sys_after_12", sys_clock, 32'd3);

    // AUTO path
    sub(7'b0000010);
    chk("auto_sel_state", 32'(state), 32'd2);
    chk("auto_sel_song", 32'(song), 32'd0);
    sub(7'b0000001);
    chk("auto_run_state", 32'(state), 32'd3);
    chk("auto_run_song", 32'(song), 32'd1);
    chk("auto_run_en", 32'(en_vec), 32'b01000);
    press(B_CAN);
    chk("auto_cancel", 32'(state), 32'd0);

    // PLAY difficulty saturation and selection
    sub(7'b0001000);
    chk("play_sel_state", 32'(state), 32'd6);
    chk("play_sel_diff", 32'(difficulty), 32'd4);
    repeat (5) press(B_UP);
    chk("diff_sat_max", 32'(difficulty), 32'd6);
    repeat (8) press(B_DN);
    chk("diff_sat_min", 32'(difficulty), 32'd0);
    press(B_UP | B_DN);
    chk("diff_up_dn", 32'(difficulty), 32'd0);
    press(B_UP);
    chk("diff_up1", 32'(difficulty), 32'd1);
    length_key = 7'b0000100;
    sub(7'b0000010);
    chk("play_run_state", 32'(state), 32'd7);
    chk("play_run_song", 32'(song), 32'd2);
    chk("play_mod", 32'(play_mod), 32'd2);
    chk("play_run_en", 32'(en_vec), 32'b00010);
    press(B_CAN);
    chk("play_cancel_state", 32'(state), 32'd0);
    chk("play_cancel_song", 32'(song), 32'd0);
    chk("play_cancel_en", 32'(en_vec), 32'd0);
    length_key = 7'b0000000;

    // STDY with ignored song keys
    sub(7'b0000100);
    chk("stdy_sel", 32'(state), 32'd4);
    sub(7'b0000100);
    chk("stdy_bad_song", 32'(state), 32'd4);
    sub(7'b0000000);
    chk("stdy_zero_key", 32'(state), 32'd4);
    sub(7'b0000011);
    chk("stdy_multihot", 32'(state), 32'd4);
    sub(7'b0000001);
    chk("stdy_run", 32'({state, en_vec}), 32'({4'd5, 5'b00100}));
    press(B_CAN);

    // MENU no-ops, FREE and submit+cancel
    sub(7'b0100000);
    chk("menu_idx5", 32'(state), 32'd0);
    press(B_CAN);
    chk("menu_cancel", 32'({state, en_vec}), 32'd0);
    sub(7'b0000001);
    chk("free", 32'({state, en_vec}), 32'({4'd1, 5'b10000}));
    note_key = 7'b0000010;
    press(B_SUB | B_CAN);
    chk("free_sub_cancel", 32'({state, en_vec}), 32'd0);

    // Full remap session
    sub(7'b0010000);
    chk("remap_enter", 32'({state, en_vec}), 32'({4'd8, 5'b00001}));
    for (int k = 0; k < NK; k++) begin
      key = 7'b1000000 >> k;
      exp_q.push_back({3'(k), key});
      sub(key);
      if (k == NK - 2) chk("remap_still", 32'(state), 32'd8);
    end
    chk("remap_done", 32'({state, en_vec}), 32'd0);
    drain("remap_full");

    // Submit then clear
    sub(7'b0010000);
    exp_q.push_back({3'd0, 7'b0000001});
    sub(7'b0000001);
    c0 = clr_cnt;
    clear_remap = 1'b1;
    repeat (2) @(negedge clk);
    clear_remap = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_count", 32'(clr_cnt - c0), 32'd1);
    chk("clr_state", 32'(state), 32'd0);
    drain("remap_clr");

    // Reset mid-session abandons the slot counter
    sub(7'b0010000);
    exp_q.push_back({3'd0, 7'b0000001});
    sub(7'b0000001);
    exp_q.push_back({3'd1, 7'b0000010});
    sub(7'b0000010);
    drain("pre_reset");
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'({state, en_vec}), 32'd0);
    chk("midrst_vals", 32'({difficulty, remap_addr, remap_data}), 32'({3'd4, 3'd0, 7'd0}));
    chk("midrst_sys", sys_clock, 32'd0);
    rst_n = 1'b1;
    sub(7'b0010000);
    exp_q.push_back({3'd0, 7'b0000100});
    sub(7'b0000100);
    drain("post_reset");

    // Same key twice in one session
    c0 = dup_cnt;
`ifdef REMAP_DUP_CHECK_EN
    sub(7'b0000100);
    chk("dup_pulse", 32'(dup_cnt - c0), 32'd1);
    drain("dup_nowrite");
    exp_q.push_back({3'd1, 7'b0001000});
    sub(7'b0001000);
    drain("dup_next_slot");
`else
    exp_q.push_back({3'd1, 7'b0000100});
    sub(7'b0000100);
    chk("dup_none", 32'(dup_cnt - c0), 32'd0);
    drain("dup_written");
`endif
    press(B_CAN);
    chk("final_state", 32'(state), 32'd0);
    chk("final_sys", sys_clock, 32'(tcyc / 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
